// File: rtl/fifo_frame_packer_pkg.sv
// fifo_frame_packer_pkg
//   Shared definitions for the frame packer: FSM state type, default frame
//   sync marker and the 8-bit additive checksum helper.
package fifo_frame_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SEQ   = 3'd2,
    ST_FETCH = 3'd3,
    ST_BYTES = 3'd4,
    ST_CSUM  = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Running checksum: plain modulo-256 sum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/fifo_frame_packer_word_serializer.sv
// word_serializer
//   Holds one WORD_BYTES-wide word and hands it out LSB byte first.
//   Ports:
//     clk_i       clock
//     rst_ni      synchronous active-low reset
//     load_i      capture word_i, byte index back to 0
//     word_i      word to serialise
//     adv_i       current byte consumed, shift to the next one
//     byte_o      current byte
//     next_byte_o byte that becomes current after adv_i
//     last_o      current byte is the last one of the word
module word_serializer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [8*WORD_BYTES-1:0] word_i,
  input  logic                    adv_i,
  output logic [7:0]              byte_o,
  output logic [7:0]              next_byte_o,
  output logic                    last_o
);

  localparam int unsigned W    = 8 * WORD_BYTES;
  localparam int unsigned IDXW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [W-1:0]    sh_q, sh_d, sh_shift;
  logic [IDXW-1:0] idx_q, idx_d;

  assign sh_shift    = sh_q >> 8;
  assign byte_o      = sh_q[7:0];
  assign next_byte_o = sh_shift[7:0];
  assign last_o      = (idx_q == IDXW'(WORD_BYTES - 1));

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (load_i) begin
      sh_d  = word_i;
      idx_d = '0;
    end else if (adv_i) begin
      sh_d  = sh_shift;
      idx_d = idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer
//   Pops sample words from a simple_fifo and emits fixed-length frames as a
//   valid/ready byte stream: SYNC_BYTE, seq, payload (LSB first), checksum.
//   The checksum is the mod-256 sum of seq and every payload byte.
//   Ports:
//     clk          clock, rising edge
//     rst_n        synchronous active-low reset
//     fifo_nempty  FIFO has data
//     fifo_data    FIFO head word
//     fifo_pop     pop strobe (combinational, only in FETCH)
//     tx_valid     registered byte valid
//     tx_ready     sink accepts when tx_valid && tx_ready
//     tx_data      registered byte
//     frame_done   one-cycle pulse after the checksum byte is accepted
//     busy         FSM not idle
module fifo_frame_packer
  import fifo_frame_packer_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned FRAME_WORDS = 8,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_nempty,
  input  logic [8*WORD_BYTES-1:0] fifo_data,
  output logic                    fifo_pop,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    frame_done,
  output logic                    busy
);

  state_e     state_q, state_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] seq_q, seq_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       frame_done_q, frame_done_d;

  logic       accept;
  logic       ser_load, ser_adv, ser_last;
  logic [7:0] ser_byte, ser_next;

  assign accept     = tx_valid_q && tx_ready;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

  word_serializer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_ser (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (ser_load),
    .word_i      (fifo_data),
    .adv_i       (ser_adv),
    .byte_o      (ser_byte),
    .next_byte_o (ser_next),
    .last_o      (ser_last)
  );

  // The output byte register is reloaded on the same edge that accepts the
  // previous byte, so back-to-back bytes need no bubble; the only gaps are
  // the FETCH cycle per word and SYNC's first load after IDLE.
  always_comb begin
    state_d      = state_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    seq_d        = seq_q;
    csum_d       = csum_q;
    wcnt_d       = wcnt_q;
    frame_done_d = 1'b0;
    ser_load     = 1'b0;
    ser_adv      = 1'b0;
    fifo_pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_nempty) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end else if (tx_ready) begin
          tx_data_d = seq_q;
          state_d   = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          csum_d     = seq_q;
          wcnt_d     = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fifo_nempty) begin
          fifo_pop   = 1'b1;
          ser_load   = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = fifo_data[7:0];
          state_d    = ST_BYTES;
        end
      end
      ST_BYTES: begin
        if (accept) begin
          ser_adv = 1'b1;
          csum_d  = csum_add(csum_q, ser_byte);
          if (!ser_last) begin
            tx_data_d = ser_next;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            if (wcnt_q == 8'(FRAME_WORDS - 1)) begin
              tx_data_d = csum_d;
              state_d   = ST_CSUM;
            end else begin
              tx_valid_d = 1'b0;
              state_d    = ST_FETCH;
            end
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
          seq_d        = seq_q + 8'd1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      seq_q        <= '0;
      csum_q       <= '0;
      wcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      seq_q        <= seq_d;
      csum_q       <= csum_d;
      wcnt_q       <= wcnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
